pwm_controller: RTL and testbench



---
 rtl/pwm_ctrl_pkg.sv | 14 +
 rtl/pwm_prescaler.sv | 34 +++
 rtl/pwm_controller.sv | 117 +++++++++++
 tb/tb_pwm_controller.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM output controller.
package pwm_ctrl_pkg;

    localparam int unsigned PWM_CNT_W = 8;
    localparam int unsigned NUM_OUT   = 16;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one tick every CLK_DIV cycles, restartable via clr.
module pwm_prescaler #(
    parameter int unsigned CLK_DIV = 3000,
    parameter int unsigned DIV_W   = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick = (div_q == DIV_MAX);

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (clr || tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/pwm_controller.sv
// 16-pin static/PWM driver with period-aligned double-buffered configuration
// and an immediate disable path through the live output-enable bits.
module pwm_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 3000,
    parameter int unsigned DIV_W   = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_OUT-1:0]   en_out,
    input  logic [NUM_OUT-1:0]   en_pwm_mode,
    input  logic [PWM_CNT_W-1:0] pwm_duty,
    input  logic                 cfg_valid,
    output logic [NUM_OUT-1:0]   out,
    output logic                 period_start,
    output logic                 update_pending
);

    state_e                 state_q, state_d;
    logic [PWM_CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0]     en_sh_q, en_sh_d;
    logic [NUM_OUT-1:0]     mode_sh_q, mode_sh_d;
    logic [PWM_CNT_W-1:0]   duty_sh_q, duty_sh_d;
    logic [NUM_OUT-1:0]     out_q, out_d;
    logic                   period_start_q;
    logic                   update_pending_q;

    logic tick;
    logic clr_c;
    logic load_c;
    logic boundary_c;
    logic pwm_hi_c;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_c),
        .tick  (tick)
    );

    assign boundary_c = tick && (cnt_q == PWM_CNT_W'(255));

    // Config FSM: a write arms PEND; shadows reload only on a period boundary.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        clr_c   = 1'b0;
        case (state_q)
            LOAD: begin
                load_c  = 1'b1;
                clr_c   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (cfg_valid && boundary_c) begin
                    load_c = 1'b1;
                end else if (cfg_valid) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (boundary_c) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        en_sh_d   = load_c ? en_out      : en_sh_q;
        mode_sh_d = load_c ? en_pwm_mode : mode_sh_q;
        duty_sh_d = load_c ? pwm_duty    : duty_sh_q;
        if (clr_c) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + PWM_CNT_W'(1);
        end
        pwm_hi_c = (duty_sh_q == DUTY_FULL) || (cnt_q < duty_sh_q);
        out_d    = en_out & en_sh_q & (~mode_sh_q | {NUM_OUT{pwm_hi_c}});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= LOAD;
            cnt_q            <= '0;
            en_sh_q          <= '0;
            mode_sh_q        <= '0;
            duty_sh_q        <= '0;
            out_q            <= '0;
            period_start_q   <= 1'b0;
            update_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            en_sh_q          <= en_sh_d;
            mode_sh_q        <= mode_sh_d;
            duty_sh_q        <= duty_sh_d;
            out_q            <= out_d;
            period_start_q   <= boundary_c;
            update_pending_q <= (state_d == PEND);
        end
    end

    assign out            = out_q;
    assign period_start   = period_start_q;
    assign update_pending = update_pending_q;

endmodule

// File: tb/tb_pwm_controller.sv
// Self-checking bench for pwm_controller at CLK_DIV=2 (512-cycle PWM period).
module tb_pwm_controller;

    localparam int PER = 512;

    logic        clk;
    logic        rst_n;
    logic [15:0] en_out;
    logic [15:0] en_pwm_mode;
    logic [7:0]  pwm_duty;
    logic        cfg_valid;
    logic [15:0] out;
    logic        period_start;
    logic        update_pending;

    typedef struct {
        int hi0;
        int last_hi;
        int pend;
    } per_exp_t;

    per_exp_t    sb[$];
    logic [15:0] exp_out[$];

    int t;
    int vectors;
    int miscompares;

    pwm_controller #(
        .CLK_DIV (2),
        .DIV_W   (12)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_out         (en_out),
        .en_pwm_mode    (en_pwm_mode),
        .pwm_duty       (pwm_duty),
        .cfg_valid      (cfg_valid),
        .out            (out),
        .period_start   (period_start),
        .update_pending (update_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic goto(input int p);
        do step(); while ((t % PER) != p);
    endtask

    // Measures one full period starting at a period start; optionally writes
    // new config with a one-cycle cfg_valid during cycle wpos of that period.
    task automatic run_period(input int wpos, input logic [7:0] wduty,
                              input logic [15:0] wen, input logic [15:0] wmode,
                              output int hi0, output int last_hi, output int hi_up,
                              output int pend, output int ps_end, output int ps_other);
        hi0 = 0; last_hi = 0; hi_up = 0; pend = 0; ps_end = 0; ps_other = 0;
        for (int i = 1; i <= PER; i++) begin
            if (i - 1 == wpos) begin
                pwm_duty    = wduty;
                en_out      = wen;
                en_pwm_mode = wmode;
                cfg_valid   = 1'b1;
            end
            step();
            cfg_valid = 1'b0;
            if (out[0]) begin
                hi0++;
                last_hi = i;
            end
            if (out[15:1] != 15'd0) hi_up++;
            if (update_pending) pend++;
            if (period_start) begin
                if (i == PER) ps_end = 1;
                else ps_other++;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] e;
        rst_n = 1'b0; cfg_valid = 1'b0;
        en_out = 16'h0001; en_pwm_mode = 16'h0001; pwm_duty = 8'h80;
        exp_out.push_back(16'h0000);
        exp_out.push_back(16'h0000);
        repeat (2) @(posedge clk);
        #1;
        e = exp_out.pop_front();
        vectors++;
        if (out !== e) begin miscompares++; $display("FAIL reset_out: got %h exp %h", out, e); end
        vectors++;
        if (period_start !== 1'b0) begin miscompares++; $display("FAIL reset_ps: got %b exp 0", period_start); end
        vectors++;
        if (update_pending !== 1'b0) begin miscompares++; $display("FAIL reset_pend: got %b exp 0", update_pending); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        t = 0;
        e = exp_out.pop_front();
        vectors++;
        if (out !== e) begin miscompares++; $display("FAIL load_out: got %h exp %h", out, e); end
        vectors++;
        if (update_pending !== 1'b0) begin miscompares++; $display("FAIL load_pend: got %b exp 0", update_pending); end
    endtask

    task automatic test_basic_pwm();
        per_exp_t e;
        int hi0, last_hi, hi_up, pend, ps_end, ps_other;
        sb.push_back('{256, 256, 0});
        run_period(-1, pwm_duty, en_out, en_pwm_mode, hi0, last_hi, hi_up, pend, ps_end, ps_other);
        e = sb.pop_front();
        vectors++;
        if (hi0 !== e.hi0) begin miscompares++; $display("FAIL basic_hi: got %0d exp %0d", hi0, e.hi0); end
        vectors++;
        if (last_hi !== e.last_hi) begin miscompares++; $display("FAIL basic_last_hi: got %0d exp %0d", last_hi, e.last_hi); end
        vectors++;
        if (hi_up !== 0) begin miscompares++; $display("FAIL basic_upper: got %0d cycles exp 0", hi_up); end
        vectors++;
        if (ps_end !== 1) begin miscompares++; $display("FAIL basic_ps_end: got %0d exp 1", ps_end); end
        vectors++;
        if (ps_other !== 0) begin miscompares++; $display("FAIL basic_ps_other: got %0d exp 0", ps_other); end
        vectors++;
        if (pend !== e.pend) begin miscompares++; $display("FAIL basic_pend: got %0d exp %0d", pend, e.pend); end
    endtask

    task automatic test_duty_extremes();
        per_exp_t e;
        int hi0, last_hi, hi_up, pend, ps_end, ps_other;
        logic [7:0] wd[3];
        int wp[3];
        wd[0] = 8'h00; wd[1] = 8'hFF; wd[2] = 8'hFF;
        wp[0] = 100;   wp[1] = 100;   wp[2] = -1;
        sb.push_back('{256, 256, 411});
        sb.push_back('{0, 0, 411});
        sb.push_back('{512, 512, 0});
        for (int k = 0; k < 3; k++) begin
            run_period(wp[k], wd[k], en_out, en_pwm_mode, hi0, last_hi, hi_up, pend, ps_end, ps_other);
            e = sb.pop_front();
            vectors++;
            if (hi0 !== e.hi0) begin miscompares++; $display("FAIL extremes_hi[%0d]: got %0d exp %0d", k, hi0, e.hi0); end
            vectors++;
            if (last_hi !== e.last_hi) begin miscompares++; $display("FAIL extremes_last_hi[%0d]: got %0d exp %0d", k, last_hi, e.last_hi); end
            vectors++;
            if (pend !== e.pend) begin miscompares++; $display("FAIL extremes_pend[%0d]: got %0d exp %0d", k, pend, e.pend); end
        end
    endtask

    task automatic test_midperiod_update();
        per_exp_t e;
        int hi0, last_hi, hi_up, pend, ps_end, ps_other;
        logic [7:0] wd[3];
        int wp[3];
        wd[0] = 8'h80; wd[1] = 8'h40; wd[2] = 8'h40;
        wp[0] = 100;   wp[1] = 100;   wp[2] = -1;
        sb.push_back('{512, 512, 411});
        sb.push_back('{256, 256, 411});
        sb.push_back('{128, 128, 0});
        for (int k = 0; k < 3; k++) begin
            run_period(wp[k], wd[k], en_out, en_pwm_mode, hi0, last_hi, hi_up, pend, ps_end, ps_other);
            e = sb.pop_front();
            vectors++;
            if (hi0 !== e.hi0) begin miscompares++; $display("FAIL midupd_hi[%0d]: got %0d exp %0d", k, hi0, e.hi0); end
            vectors++;
            if (last_hi !== e.last_hi) begin miscompares++; $display("FAIL midupd_last_hi[%0d]: got %0d exp %0d", k, last_hi, e.last_hi); end
            vectors++;
            if (pend !== e.pend) begin miscompares++; $display("FAIL midupd_pend[%0d]: got %0d exp %0d", k, pend, e.pend); end
        end
    endtask

    task automatic test_boundary_cfg();
        per_exp_t e;
        int hi0, last_hi, hi_up, pend, ps_end, ps_other;
        int wp[2];
        wp[0] = PER - 1; wp[1] = -1;
        sb.push_back('{128, 128, 0});
        sb.push_back('{64, 64, 0});
        for (int k = 0; k < 2; k++) begin
            run_period(wp[k], 8'h20, en_out, en_pwm_mode, hi0, last_hi, hi_up, pend, ps_end, ps_other);
            e = sb.pop_front();
            vectors++;
            if (hi0 !== e.hi0) begin miscompares++; $display("FAIL bnd_hi[%0d]: got %0d exp %0d", k, hi0, e.hi0); end
            vectors++;
            if (last_hi !== e.last_hi) begin miscompares++; $display("FAIL bnd_last_hi[%0d]: got %0d exp %0d", k, last_hi, e.last_hi); end
            vectors++;
            if (pend !== e.pend) begin miscompares++; $display("FAIL bnd_pend[%0d]: got %0d exp %0d", k, pend, e.pend); end
        end
    endtask

    task automatic test_fast_disable();
        per_exp_t e;
        logic [15:0] eo;
        int hi0, last_hi, hi_up, pend, ps_end, ps_other;
        sb.push_back('{64, 64, 411});
        run_period(100, 8'h20, 16'hFFFF, 16'h0000, hi0, last_hi, hi_up, pend, ps_end, ps_other);
        e = sb.pop_front();
        vectors++;
        if (hi0 !== e.hi0) begin miscompares++; $display("FAIL fd_setup_hi: got %0d exp %0d", hi0, e.hi0); end
        vectors++;
        if (hi_up !== 0) begin miscompares++; $display("FAIL fd_setup_upper: got %0d cycles exp 0", hi_up); end
        exp_out.push_back(16'hFFFF);
        goto(200);
        eo = exp_out.pop_front();
        vectors++;
        if (out !== eo) begin miscompares++; $display("FAIL fd_static_all: got %h exp %h", out, eo); end
        en_out = 16'hFFF7; cfg_valid = 1'b1;
        exp_out.push_back(16'hFFF7);
        step();
        cfg_valid = 1'b0;
        eo = exp_out.pop_front();
        vectors++;
        if (out !== eo) begin miscompares++; $display("FAIL fd_disable_1cyc: got %h exp %h", out, eo); end
        goto(100);
        en_out = 16'hFFFF; cfg_valid = 1'b1;
        exp_out.push_back(16'hFFF7);
        exp_out.push_back(16'hFFF7);
        exp_out.push_back(16'hFFFF);
        step();
        cfg_valid = 1'b0;
        goto(300);
        eo = exp_out.pop_front();
        vectors++;
        if (out !== eo) begin miscompares++; $display("FAIL fd_reenable_wait: got %h exp %h", out, eo); end
        goto(0);
        eo = exp_out.pop_front();
        vectors++;
        if (out !== eo) begin miscompares++; $display("FAIL fd_reenable_boundary: got %h exp %h", out, eo); end
        step();
        eo = exp_out.pop_front();
        vectors++;
        if (out !== eo) begin miscompares++; $display("FAIL fd_reenable_after: got %h exp %h", out, eo); end
    endtask

    task automatic test_mid_reset();
        per_exp_t e;
        logic [15:0] eo;
        int hi0, last_hi, hi_up, pend, ps_end, ps_other;
        goto(100);
        en_out = 16'h0001; en_pwm_mode = 16'h0001; pwm_duty = 8'h80; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        goto(40);
        pwm_duty = 8'h40; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        exp_out.push_back(16'h0001);
        goto(50);
        eo = exp_out.pop_front();
        vectors++;
        if (out !== eo) begin miscompares++; $display("FAIL mr_pwm_high: got %h exp %h", out, eo); end
        vectors++;
        if (update_pending !== 1'b1) begin miscompares++; $display("FAIL mr_pend_before: got %b exp 1", update_pending); end
        rst_n = 1'b0;
        exp_out.push_back(16'h0000);
        step();
        rst_n = 1'b1;
        eo = exp_out.pop_front();
        vectors++;
        if (out !== eo) begin miscompares++; $display("FAIL mr_out_reset: got %h exp %h", out, eo); end
        vectors++;
        if (update_pending !== 1'b0) begin miscompares++; $display("FAIL mr_pend_reset: got %b exp 0", update_pending); end
        step();
        t = 0;
        sb.push_back('{128, 128, 0});
        run_period(-1, pwm_duty, en_out, en_pwm_mode, hi0, last_hi, hi_up, pend, ps_end, ps_other);
        e = sb.pop_front();
        vectors++;
        if (hi0 !== e.hi0) begin miscompares++; $display("FAIL mr_hi: got %0d exp %0d", hi0, e.hi0); end
        vectors++;
        if (last_hi !== e.last_hi) begin miscompares++; $display("FAIL mr_last_hi: got %0d exp %0d", last_hi, e.last_hi); end
        vectors++;
        if (ps_end !== 1 || ps_other !== 0) begin
            miscompares++;
            $display("FAIL mr_period_start: got end=%0d other=%0d exp end=1 other=0", ps_end, ps_other);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        t = 0;
        test_reset();
        test_basic_pwm();
        test_duty_extremes();
        test_midperiod_update();
        test_boundary_cfg();
        test_fast_disable();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
